mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview: Shares the single AXI read channel of the cache-AXI bridge among three requesters: icache line refill, dcache line refill and uncached data load. Each request is latched at grant and its address and burst length are issued on a valid/ready address handshake. Returned beats are assembled into a 128-bit line, or a single 32-bit word for uncached loads, and a completion pulse goes back to the owner. Priority is fixed (uncache > data > inst), with a starvation guard for instruction fetch and a cancel path for icache flushes.

Parameters:
STARVE_LIMIT  4  consecutive lost arbitrations, while inst_req_i is held high, after which inst wins the next grant
CNT_W  3  width of the starvation counter; must hold STARVE_LIMIT

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
inst_req_i  in  1  icache refill request; level, held until ack
inst_addr_i  in  32  icache miss address
inst_cancel_i  in  1  icache flush; discard in-flight inst refill
inst_ack_o  out  1  grant pulse to icache
inst_rvalid_o  out  1  line-ready pulse
inst_rdata_o  out  128  refilled line; beat0 in [31:0]
data_req_i  in  1  dcache refill request
data_addr_i  in  32  dcache miss address
data_ack_o  out  1  grant pulse
data_rvalid_o  out  1  line-ready pulse
data_rdata_o  out  128  refilled line
unc_req_i  in  1  uncached load request
unc_addr_i  in  32  uncached address, not aligned
unc_ack_o  out  1  grant pulse
unc_rvalid_o  out  1  word-ready pulse
unc_rdata_o  out  32  loaded word
mem_arvalid_o  out  1  address valid to bridge
mem_araddr_o  out  32  burst address
mem_arlen_o  out  8  beats minus one
mem_arready_i  in  1  address accepted
mem_rvalid_i  in  1  read beat valid
mem_rdata_i  in  32  read beat
mem_rlast_i  in  1  final beat
mem_rready_o  out  1  beat accept
busy_o  out  1  state != IDLE
proto_err_o  out  1  sticky: rlast did not coincide with the expected final beat

Behaviour:
- Reset (async): state=IDLE; all outputs, rdata registers, owner, beat counter, drop flag, starvation counter and proto_err_o are 0.
- States:
  - IDLE: when any req is high, grant this cycle and go to ADDR.
  - ADDR: mem_arvalid_o=1; on mem_arready_i go to DATA.
  - DATA: mem_rready_o=1; on the completing beat go to IDLE.
- Grant order:
  - Inst wins if inst_req_i=1 and starve_cnt>=STARVE_LIMIT.
  - Otherwise unc > data > inst.
- ack_o: combinational, one cycle, asserted in the IDLE grant cycle. The requester may drop req and address from the next cycle.
- At grant, latch owner and address.
  - Line owners: araddr={addr[31:4],4'b0}, arlen=3.
  - Uncache: araddr=addr unchanged, arlen=0.
- mem_araddr_o and mem_arlen_o stay stable throughout ADDR.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each grant to data or unc while inst_req_i=1.
  - Cleared on inst grant, or on any cycle with inst_req_i=0.
- Beat handling:
  - Each accepted beat (DATA & mem_rvalid_i) writes mem_rdata_i into the owner's buffer lane beat_cnt*32; beat_cnt increments (2 bits).
  - Uncache writes unc_rdata_o.
  - Completing beat = accepted beat with mem_rlast_i=1.
  - If beat_cnt != arlen[1:0] on the completing beat, set proto_err_o. The transfer still completes.
- Completion pulse: registered. The owner's rvalid_o goes high for exactly one cycle, the cycle after the completing beat. rdata_o is valid then and is held until that requester's next beat write.
- Cancel:
  - inst_cancel_i while owner=inst in ADDR or DATA, including the completing-beat cycle, sets the drop flag.
  - The burst still drains fully; inst_rvalid_o is suppressed.
  - The drop flag clears on return to IDLE.
  - Cancel in IDLE, or with another owner, is ignored. A same-cycle inst_req_i is still arbitrated.
- Back-to-back: a new grant is possible in the IDLE cycle right after completion, so the minimum request-to-request spacing is 3 cycles plus bus latency.
- Requests arriving outside IDLE wait; there is no queuing beyond the req level.

Test Plan:
- Reset mid-burst: assert rst in DATA with 2 of 4 beats received -> state IDLE immediately; all outputs 0; no rvalid pulse after release.
- Inst refill: inst_req, addr 0x1C00_0024 -> ack same cycle; araddr 0x1C00_0020, arlen 3; beats 0x11,0x22,0x33,0x44 (rlast on 4th) -> inst_rvalid_o one cycle later, rdata 0x00000044_00000033_00000022_00000011.
- Simultaneous unc (0xBFAF_8004) + data + inst -> unc granted with araddr 0xBFAF_8004, arlen 0; single beat 0xDEAD_BEEF -> unc_rvalid_o pulse, unc_rdata_o 0xDEADBEEF. Next grant goes to data.
- Starvation: inst_req held while data_req reasserts continuously; STARVE_LIMIT=4 -> inst granted on the 5th arbitration; starve_cnt then 0.
- Cancel: inst burst in flight, pulse inst_cancel_i after beat 1 -> all 4 beats accepted, no inst_rvalid_o, busy_o drops after the last beat; a following data request is served normally.
- Protocol error: line burst with rlast on beat 2 -> completion after 2 beats, proto_err_o=1 and stays 1 until reset.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one AXI-style read channel among the icache refill,
// dcache refill and uncached load paths. Fixed priority unc > data > inst,
// with a starvation guard that lets a long-waiting inst fetch win. Line
// owners get a 4-beat aligned burst assembled into 128 bits; uncached loads
// get a single unaligned beat. An icache flush can drop an in-flight inst refill.
module mem_read_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_req_i,
  input  logic [31:0]  inst_addr_i,
  input  logic         inst_cancel_i,
  output logic         inst_ack_o,
  output logic         inst_rvalid_o,
  output logic [127:0] inst_rdata_o,
  input  logic         data_req_i,
  input  logic [31:0]  data_addr_i,
  output logic         data_ack_o,
  output logic         data_rvalid_o,
  output logic [127:0] data_rdata_o,
  input  logic         unc_req_i,
  input  logic [31:0]  unc_addr_i,
  output logic         unc_ack_o,
  output logic         unc_rvalid_o,
  output logic [31:0]  unc_rdata_o,
  output logic         mem_arvalid_o,
  output logic [31:0]  mem_araddr_o,
  output logic [7:0]   mem_arlen_o,
  input  logic         mem_arready_i,
  input  logic         mem_rvalid_i,
  input  logic [31:0]  mem_rdata_i,
  input  logic         mem_rlast_i,
  output logic         mem_rready_o,
  output logic         busy_o,
  output logic         proto_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  typedef enum logic [1:0] {OWN_INST, OWN_DATA, OWN_UNC} owner_t;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [7:0]       arlen_q, arlen_d;
  logic [1:0]       beat_cnt_q, beat_cnt_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             perr_q, perr_d;
  logic             inst_rv_q, inst_rv_d;
  logic             data_rv_q, data_rv_d;
  logic             unc_rv_q, unc_rv_d;
  logic [127:0]     inst_buf_q, data_buf_q;
  logic [31:0]      unc_buf_q;

  logic             grant;
  owner_t           grant_own;
  logic             any_req;
  logic             starve_win;
  logic             beat_acc;
  logic             beat_last;
  logic [6:0]       lane_lsb;

  assign any_req    = inst_req_i | data_req_i | unc_req_i;
  assign starve_win = inst_req_i && (starve_q >= STARVE_MAX);
  assign beat_acc   = (state_q == S_DATA) && mem_rvalid_i;
  assign beat_last  = beat_acc && mem_rlast_i;
  assign lane_lsb   = {beat_cnt_q, 5'd0};

  // Next-state, grant selection, request latching and bookkeeping.
  always_comb begin
    // NOTE: every signal driven here is given a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    owner_d    = owner_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    beat_cnt_d = beat_cnt_q;
    drop_d     = drop_q;
    starve_d   = starve_q;
    perr_d     = perr_q;
    grant      = 1'b0;
    grant_own  = OWN_INST;

    case (state_q)
      S_IDLE: begin
        if (!rst && any_req) begin
          grant = 1'b1;
          if (starve_win)      grant_own = OWN_INST;
          else if (unc_req_i)  grant_own = OWN_UNC;
          else if (data_req_i) grant_own = OWN_DATA;
          else                 grant_own = OWN_INST;
          owner_d    = grant_own;
          state_d    = S_ADDR;
          beat_cnt_d = 2'd0;
          case (grant_own)
            OWN_UNC: begin
              araddr_d = unc_addr_i;
              arlen_d  = 8'd0;
            end
            OWN_DATA: begin
              araddr_d = data_addr_i & 32'hFFFF_FFF0;
              arlen_d  = 8'd3;
            end
            default: begin
              araddr_d = inst_addr_i & 32'hFFFF_FFF0;
              arlen_d  = 8'd3;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (mem_arready_i) state_d = S_DATA;
      end
      S_DATA: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 2'd1;
          if (mem_rlast_i) begin
            state_d    = S_IDLE;
            beat_cnt_d = 2'd0;
            // The transfer still completes; the mismatch is only recorded.
            if (beat_cnt_q != arlen_q[1:0]) perr_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush of the icache while it owns the channel: drain, but do not deliver.
    if ((state_q != S_IDLE) && (owner_q == OWN_INST) && inst_cancel_i) drop_d = 1'b1;
    if (beat_last) drop_d = 1'b0;

    // Count arbitrations that inst loses while it keeps asking.
    if (!inst_req_i)                              starve_d = '0;
    else if (grant && (grant_own == OWN_INST))    starve_d = '0;
    else if (grant && (starve_q < STARVE_MAX))    starve_d = starve_q + 1'b1;
  end

  // Completion pulses, registered so they land the cycle after the last beat.
  always_comb begin
    inst_rv_d = beat_last && (owner_q == OWN_INST) && !drop_q && !inst_cancel_i;
    data_rv_d = beat_last && (owner_q == OWN_DATA);
    unc_rv_d  = beat_last && (owner_q == OWN_UNC);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_INST;
      araddr_q   <= '0;
      arlen_q    <= '0;
      beat_cnt_q <= '0;
      drop_q     <= 1'b0;
      starve_q   <= '0;
      perr_q     <= 1'b0;
      inst_rv_q  <= 1'b0;
      data_rv_q  <= 1'b0;
      unc_rv_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge value of every other register.
      state_q    <= state_d;
      owner_q    <= owner_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
      drop_q     <= drop_d;
      starve_q   <= starve_d;
      perr_q     <= perr_d;
      inst_rv_q  <= inst_rv_d;
      data_rv_q  <= data_rv_d;
      unc_rv_q   <= unc_rv_d;
    end
  end

  // Line/word assembly: each accepted beat lands in the owner's lane.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these buffers are plain flops rather than a RAM, so they take the
    // reset and read back as zero until their owner's first beat.
    if (rst) begin
      inst_buf_q <= '0;
      data_buf_q <= '0;
      unc_buf_q  <= '0;
    end else if (beat_acc) begin
      case (owner_q)
        OWN_INST: inst_buf_q[lane_lsb +: 32] <= mem_rdata_i;
        OWN_DATA: data_buf_q[lane_lsb +: 32] <= mem_rdata_i;
        OWN_UNC:  unc_buf_q                  <= mem_rdata_i;
        default:  ;
      endcase
    end
  end

  assign inst_ack_o    = grant && (grant_own == OWN_INST);
  assign data_ack_o    = grant && (grant_own == OWN_DATA);
  assign unc_ack_o     = grant && (grant_own == OWN_UNC);
  assign inst_rvalid_o = inst_rv_q;
  assign data_rvalid_o = data_rv_q;
  assign unc_rvalid_o  = unc_rv_q;
  assign inst_rdata_o  = inst_buf_q;
  assign data_rdata_o  = data_buf_q;
  assign unc_rdata_o   = unc_buf_q;
  assign mem_arvalid_o = (state_q == S_ADDR);
  assign mem_araddr_o  = araddr_q;
  assign mem_arlen_o   = arlen_q;
  assign mem_rready_o  = (state_q == S_DATA);
  assign busy_o        = (state_q != S_IDLE);
  assign proto_err_o   = perr_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: a grant model predicts every
// arbitration and address, a bus responder supplies beats and records the
// expected line/word, and a monitor pops and compares on each completion.
module tb_mem_read_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int I = 0, D = 1, U = 2;

  typedef struct { int owner; logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { int owner; logic [127:0] data; } cmp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         inst_cancel_i;
  logic         inst_ack_o, inst_rvalid_o, data_ack_o, data_rvalid_o, unc_ack_o, unc_rvalid_o;
  logic [127:0] inst_rdata_o, data_rdata_o;
  logic [31:0]  unc_rdata_o;
  logic         mem_arvalid_o, mem_arready_i, mem_rvalid_i, mem_rlast_i, mem_rready_o;
  logic [31:0]  mem_araddr_o, mem_rdata_i;
  logic [7:0]   mem_arlen_o;
  logic         busy_o, proto_err_o;

  // Requester drive state
  logic        req [3];
  logic [31:0] req_addr [3];
  bit          hold [3];
  bit          pend_go [3];
  logic [31:0] pend_addr [3];
  bit          acked [3];
  int          auto_pct = 0;

  // Reference model / scoreboard state
  int           n_tests = 0, n_fail = 0;
  int           starve_m = 0;
  bit           act_valid = 0;
  int           act_owner = 0;
  bit           drop_m = 0;
  ar_t          ar_q [$];
  cmp_t         exp_q [$];
  bit           due_set = 0;
  logic [2:0]   due_vec = '0;
  logic [127:0] exp_buf [3];
  bit           exp_perr = 0;
  int           grant_log [$];
  int           rv_cnt [3];

  // Responder controls
  bit          slave_en = 0;
  int          gap_max = 0;
  int          early = 0;
  int          cancel_at = -1;
  bit          rand_cancel = 0;
  logic [31:0] beat_q [$];

  mem_read_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(req[I]), .inst_addr_i(req_addr[I]), .inst_cancel_i(inst_cancel_i),
    .inst_ack_o(inst_ack_o), .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
    .data_req_i(req[D]), .data_addr_i(req_addr[D]),
    .data_ack_o(data_ack_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .unc_req_i(req[U]), .unc_addr_i(req_addr[U]),
    .unc_ack_o(unc_ack_o), .unc_rvalid_o(unc_rvalid_o), .unc_rdata_o(unc_rdata_o),
    .mem_arvalid_o(mem_arvalid_o), .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o),
    .mem_arready_i(mem_arready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_rlast_i(mem_rlast_i), .mem_rready_o(mem_rready_o),
    .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {busy_o, mem_arvalid_o, mem_rready_o, inst_ack_o, data_ack_o, unc_ack_o,
                          inst_rvalid_o, data_rvalid_o, unc_rvalid_o, proto_err_o}, '0);
    check({tag, "_ar"}, {mem_araddr_o, mem_arlen_o}, '0);
    check({tag, "_inst_rdata"}, inst_rdata_o, '0);
    check({tag, "_data_rdata"}, data_rdata_o, '0);
    check({tag, "_unc_rdata"}, unc_rdata_o, '0);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((act_valid || req[0] || req[1] || req[2] || pend_go[0] || pend_go[1] || pend_go[2])
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("quiet_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic issue(input int who, input logic [31:0] addr);
    pend_addr[who] = addr;
    pend_go[who]   = 1'b1;
  endtask

  // Requester driver: hold each request until its grant, then drop or renew it.
  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; req_addr[i] = '0; hold[i] = 0; pend_go[i] = 0; acked[i] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (acked[i]) begin
          acked[i] = 0;
          if (hold[i]) req_addr[i] = $urandom;
          else         req[i] = 1'b0;
        end
        if (!req[i]) begin
          if (pend_go[i]) begin
            req[i] = 1'b1; req_addr[i] = pend_addr[i]; pend_go[i] = 0;
          end else if (auto_pct > 0 && $urandom_range(99) < auto_pct) begin
            req[i] = 1'b1; req_addr[i] = $urandom;
          end
        end
      end
    end
  end

  // Monitor: predicts grants from the priority rules and checks completions.
  initial begin
    logic [2:0] rv_vec, ack_vec, exp_ack;
    int w;
    cmp_t e;
    for (int i = 0; i < 3; i++) begin exp_buf[i] = '0; rv_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_q.delete(); exp_q.delete();
        act_valid = 0; drop_m = 0; starve_m = 0; due_set = 0; due_vec = '0; exp_perr = 0;
        for (int i = 0; i < 3; i++) exp_buf[i] = '0;
        continue;
      end
      rv_vec  = {unc_rvalid_o, data_rvalid_o, inst_rvalid_o};
      ack_vec = {unc_ack_o, data_ack_o, inst_ack_o};
      for (int i = 0; i < 3; i++) if (rv_vec[i]) rv_cnt[i]++;
      if (due_set || rv_vec != 3'b000) check("rvalid_vec", rv_vec, due_vec);
      if (due_set) begin
        check("proto_err", proto_err_o, exp_perr);
        due_set = 0; due_vec = '0;
      end
      if (rv_vec != 3'b000) begin
        if (exp_q.size() == 0) check("rvalid_unexpected", rv_vec, 0);
        else begin
          e = exp_q.pop_front();
          case (e.owner)
            I:       check("inst_rdata", inst_rdata_o, e.data);
            D:       check("data_rdata", data_rdata_o, e.data);
            default: check("unc_rdata", {96'b0, unc_rdata_o}, e.data);
          endcase
        end
      end
      if (act_valid && inst_cancel_i && act_owner == I) drop_m = 1;
      check("busy", busy_o, act_valid);
      if (!act_valid && (req[I] || req[D] || req[U])) begin
        if (req[I] && starve_m >= STARVE_LIMIT) w = I;
        else if (req[U])                        w = U;
        else if (req[D])                        w = D;
        else                                    w = I;
        exp_ack = '0; exp_ack[w] = 1'b1;
        check("ack_vec", ack_vec, exp_ack);
        if (w == U) ar_q.push_back('{owner: U, addr: req_addr[U], len: 8'd0});
        else        ar_q.push_back('{owner: w, addr: {req_addr[w][31:4], 4'h0}, len: 8'd3});
        grant_log.push_back(w);
        act_valid = 1; act_owner = w; acked[w] = 1;
        if (!req[I] || w == I) starve_m = 0;
        else if (starve_m < STARVE_LIMIT) starve_m++;
      end else begin
        if (ack_vec != 3'b000) check("ack_vec", ack_vec, 0);
        if (!req[I]) starve_m = 0;
      end
    end
  end

  // Bus responder: accepts each address phase and returns the burst.
  initial begin
    ar_t a;
    int nb, gap;
    logic [31:0] dat;
    mem_arready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_rlast_i = 0; inst_cancel_i = 0;
    forever begin
      do begin
        @(posedge clk); #1;
        inst_cancel_i = 0;
        @(negedge clk);
      end while (!(slave_en && mem_arvalid_o && ar_q.size() > 0));
      a = ar_q.pop_front();
      check("araddr", mem_araddr_o, a.addr);
      check("arlen", mem_arlen_o, a.len);
      repeat ($urandom_range(2)) begin
        @(posedge clk); #1;
        inst_cancel_i = rand_cancel && ($urandom_range(3) == 0);
        @(negedge clk);
        check("araddr_hold", {mem_arvalid_o, mem_araddr_o, mem_arlen_o}, {1'b1, a.addr, a.len});
      end
      @(posedge clk); #1;
      inst_cancel_i = 0; mem_arready_i = 1;
      @(posedge clk); #1;
      mem_arready_i = 0;
      nb = (early > 0) ? early : int'(a.len) + 1;
      for (int b = 0; b < nb; b++) begin
        mem_rvalid_i = 0; mem_rlast_i = 0; inst_cancel_i = 0;
        gap = (gap_max > 0) ? $urandom_range(gap_max) : 0;
        repeat (gap) begin @(posedge clk); #1; end
        dat = (beat_q.size() > 0) ? beat_q.pop_front() : $urandom;
        mem_rvalid_i = 1; mem_rdata_i = dat; mem_rlast_i = (b == nb - 1);
        inst_cancel_i = (b == cancel_at) || (rand_cancel && $urandom_range(7) == 0);
        if (a.owner == U) exp_buf[U] = {96'b0, dat};
        else              exp_buf[a.owner][(b % 4) * 32 +: 32] = dat;
        @(posedge clk); #1;
      end
      mem_rvalid_i = 0; mem_rlast_i = 0; inst_cancel_i = 0;
      if (((nb - 1) % 4) != int'(a.len[1:0])) exp_perr = 1;
      due_vec = '0;
      if (!(a.owner == I && drop_m)) begin
        due_vec[a.owner] = 1'b1;
        exp_q.push_back('{owner: a.owner, data: exp_buf[a.owner]});
      end
      due_set = 1; drop_m = 0; act_valid = 0;
      // Cancel in the idle cycle that follows must be ignored.
      if (rand_cancel && $urandom_range(2) == 0) inst_cancel_i = 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, rv0[3];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Reset in the middle of an inst burst, 2 of 4 beats delivered.
    @(negedge clk);
    issue(I, 32'h1C00_0100);
    n = 0;
    while (!mem_arvalid_o && n < 20) begin @(negedge clk); n++; end
    check("mid_rst_addr_phase", mem_arvalid_o, 1);
    @(posedge clk); #1 mem_arready_i = 1;
    @(posedge clk); #1 mem_arready_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA_0001;
    @(posedge clk); #1 mem_rdata_i = 32'hAAAA_0002;
    @(posedge clk); #1 mem_rvalid_i = 0;
    #2 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_rvalid", {inst_rvalid_o, data_rvalid_o, unc_rvalid_o, busy_o}, 0);
    end

    // Directed inst refill.
    slave_en = 1; gap_max = 0;
    beat_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    issue(I, 32'h1C00_0024);
    wait_quiet(100);
    check("inst_line", inst_rdata_o, 128'h00000044_00000033_00000022_00000011);

    // Three simultaneous requests: unc, then data, then inst.
    grant_log.delete(); gap_max = 1;
    beat_q = '{32'hDEAD_BEEF};
    issue(U, 32'hBFAF_8004); issue(D, $urandom); issue(I, $urandom);
    wait_quiet(300);
    check("unc_word", unc_rdata_o, 32'hDEAD_BEEF);
    check("order_len", grant_log.size(), 3);
    check("order_0", grant_log[0], U);
    check("order_1", grant_log[1], D);
    check("order_2", grant_log[2], I);

    // Starvation guard: data keeps asking, inst must win the 5th arbitration.
    grant_log.delete(); gap_max = 0;
    hold[D] = 1;
    issue(D, $urandom); issue(I, $urandom);
    n = 0;
    while (grant_log.size() < 5 && n < 400) begin @(negedge clk); n++; end
    hold[D] = 0;
    wait_quiet(300);
    check("starve_len", grant_log.size() >= 5, 1);
    for (int k = 0; k < 4; k++) check("starve_data", grant_log[k], D);
    check("starve_inst", grant_log[4], I);
    // Counter is back at zero: a fresh inst+data pair goes to data first.
    grant_log.delete();
    issue(D, $urandom); issue(I, $urandom);
    wait_quiet(300);
    check("after_starve_len", grant_log.size(), 2);
    check("after_starve_0", grant_log[0], D);

    // Cancel an in-flight inst burst, then serve data normally.
    for (int i = 0; i < 3; i++) rv0[i] = rv_cnt[i];
    gap_max = 1; cancel_at = 1;
    issue(I, 32'h0040_1230);
    wait_quiet(200);
    cancel_at = -1;
    issue(D, 32'h0080_0040);
    wait_quiet(200);
    check("cancel_no_inst_rvalid", rv_cnt[I] - rv0[I], 0);
    check("cancel_data_served", rv_cnt[D] - rv0[D], 1);

    // Early rlast on a line burst: completes after 2 beats, error sticks.
    early = 2;
    issue(D, 32'h1000_0000);
    wait_quiet(200);
    early = 0;
    repeat (5) @(negedge clk);
    check("perr_sticky", proto_err_o, 1);

    // Randomized traffic with random cancels.
    rand_cancel = 1; gap_max = 2; auto_pct = 30;
    repeat (800) @(negedge clk);
    auto_pct = 0;
    wait_quiet(600);
    rand_cancel = 0;
    check("exp_q_drained", exp_q.size(), 0);
    check("ar_q_drained", ar_q.size(), 0);
    check("perr_still_set", proto_err_o, 1);

    // Only reset clears the error flag.
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("perr_cleared", proto_err_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
